// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master engine:
// FSM state encoding and SPI mode-0 clock constants.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD
    } state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_master_engine_if.sv
// Word handshake between the register layer (master)
// and the SPI shift engine (slave).
interface spi_master_engine_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_last;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  busy;
    logic                  done_irq;

    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy, done_irq
    );

    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid, busy, done_irq
    );

endinterface

// File: rtl/spi_sck_gen.sv
// Half-period counter and SCK toggle. The counter also
// times the SCK-low SETUP and HOLD phases when sck_en is 0.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             sck_en,
    input  logic [DIV_W-1:0] div,
    output logic             tc,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic             sck
);

    logic [DIV_W-1:0] cnt;
    logic             sck_q;

    assign tc        = cnt_en && (cnt == div);
    assign rise_tick = tc && sck_en && (sck_q == CPOL);
    assign fall_tick = tc && sck_en && (sck_q != CPOL);
    assign sck       = sck_q;

    // Counter runs 0..div while enabled; SCK flips at terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            sck_q <= CPOL;
        end else begin
            if (!cnt_en || tc) cnt <= '0;
            else               cnt <= cnt + 1'b1;
            if (!sck_en)       sck_q <= CPOL;
            else if (tc)       sck_q <= ~sck_q;
        end
    end

endmodule

// File: rtl/spi_master_engine.sv
// SPI mode-0 master shift engine: frames words from the handshake
// onto MOSI/SCK/NSS and returns words shifted in from MISO.
module spi_master_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_W      = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [DIV_W-1:0] clk_div,
    spi_master_engine_if.slave bus,
    input  logic             MISO,
    output logic             MOSI,
    output logic             SCK,
    output logic             NSS
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    state_t                state;
    state_t                state_n;
    logic [DIV_W-1:0]      div_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [BW-1:0]         bits_q;
    logic                  last_q;
    logic                  miso_q;
    logic                  act_q;
    logic                  ready_q;
    logic                  rx_valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  nss_q;
    logic                  cnt_en;
    logic                  sck_en;
    logic                  tc;
    logic                  rise_tick;
    logic                  fall_tick;
    logic                  sample;
    logic                  shift;
    logic                  xfer;
    logic                  word_end;
    logic                  hold_end;

    assign xfer     = bus.tx_valid && ready_q;
    assign cnt_en   = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign sck_en   = (state == SHIFT);
    assign sample   = (CPHA == 1'b0) ? rise_tick : fall_tick;
    assign shift    = (CPHA == 1'b0) ? fall_tick : rise_tick;
    assign word_end = shift && (bits_q == BW'(DATA_WIDTH - 1));
    assign hold_end = (state == HOLD) && tc;

    assign MOSI         = act_q & sh_q[DATA_WIDTH-1];
    assign NSS          = nss_q;
    assign bus.tx_ready = ready_q;
    assign bus.rx_data  = rx_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done_irq = done_q;

    spi_sck_gen #(
        .DIV_W (DIV_W)
    ) u_sck_gen (
        .clk       (PCLK),
        .rst       (PRESET),
        .cnt_en    (cnt_en),
        .sck_en    (sck_en),
        .div       (div_q),
        .tc        (tc),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .sck       (SCK)
    );

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; WAIT re-enters SHIFT directly, skipping SETUP.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (xfer) state_n = SETUP;
            SETUP:   if (tc) state_n = SHIFT;
            SHIFT:   if (word_end) state_n = last_q ? HOLD : WAIT;
            WAIT:    if (xfer) state_n = SHIFT;
            HOLD:    if (tc) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: word latch, shift register, pins and status pulses.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            div_q      <= '0;
            sh_q       <= '0;
            rx_q       <= '0;
            bits_q     <= '0;
            last_q     <= 1'b0;
            miso_q     <= 1'b0;
            act_q      <= 1'b0;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nss_q      <= 1'b1;
        end else begin
            ready_q    <= (state_n == IDLE) || (state_n == WAIT);
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (xfer) begin
                sh_q   <= bus.tx_data;
                last_q <= bus.tx_last;
                bits_q <= '0;
                act_q  <= 1'b1;
                nss_q  <= 1'b0;
                busy_q <= 1'b1;
                if (state == IDLE) div_q <= clk_div;
            end
            if (sample) miso_q <= MISO;
            if (shift) begin
                sh_q   <= {sh_q[DATA_WIDTH-2:0], miso_q};
                bits_q <= bits_q + 1'b1;
            end
            if (word_end) begin
                rx_q       <= {sh_q[DATA_WIDTH-2:0], miso_q};
                rx_valid_q <= 1'b1;
                act_q      <= 1'b0;
            end
            if (hold_end) begin
                nss_q  <= 1'b1;
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_engine.sv
// Directed and random frames against a bit-level reference of SPI mode 0:
// MOSI bits seen at SCK rises, words returned, frame timing.
module tb_spi_master_engine;

    logic       PCLK = 1'b0;
    logic       PRESET = 1'b0;
    logic [7:0] clk_div = 8'd0;
    logic       MISO;
    logic       MOSI;
    logic       SCK;
    logic       NSS;

    spi_master_engine_if #(.DATA_WIDTH(8)) bus ();

    spi_master_engine #(
        .DATA_WIDTH (8),
        .DIV_W      (8)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clk_div (clk_div),
        .bus     (bus.slave),
        .MISO    (MISO),
        .MOSI    (MOSI),
        .SCK     (SCK),
        .NSS     (NSS)
    );

    always #5 PCLK = ~PCLK;

    int         total = 0;
    int         bad = 0;
    int         miso_mode = 0;
    int         sbit = 0;
    int         done_cnt = 0;
    logic [7:0] slv [4];
    logic [7:0] txv [4];
    logic       mbit [$];
    time        rise_t [$];
    logic [7:0] rxq [$];
    time        done_t = 0;
    time        acc_t = 0;

    // Slave model: next bit index advances on each SCK fall, restarts when NSS rises.
    always @(negedge SCK or posedge NSS) begin
        if (NSS) sbit <= 0;
        else     sbit <= sbit + 1;
    end

    always_comb begin
        MISO = MOSI;
        if (miso_mode == 1)      MISO = 1'b1;
        else if (miso_mode == 2) MISO = slv[(sbit >> 3) & 3][7 - (sbit & 7)];
    end

    // Record what a mode-0 slave sees on each rising SCK.
    always @(posedge SCK) begin
        mbit.push_back(MOSI);
        rise_t.push_back($time);
    end

    // Collect returned words and frame-done pulses mid-cycle.
    always @(negedge PCLK) begin
        if (bus.rx_valid === 1'b1) rxq.push_back(bus.rx_data);
        if (bus.done_irq === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_t   <= $time - 5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word; called at a negedge, returns at a negedge.
    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        bus.tx_data  = d;
        bus.tx_last  = l;
        bus.tx_valid = 1'b1;
        while (bus.tx_ready !== 1'b1 && k < 2000) begin
            @(negedge PCLK);
            k++;
        end
        if (k >= 2000) chk("send_timeout", 0, 1);
        @(posedge PCLK);
        acc_t = $time;
        #1;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'hXX;
        @(negedge PCLK);
    endtask

    task automatic wait_done(input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge PCLK);
            k++;
        end
        if (k >= budget) chk("done_timeout", 0, 1);
        @(negedge PCLK);
    endtask

    task automatic wait_rises(input int target);
        int k = 0;
        while (rise_t.size() < target && k < 2000) begin
            @(negedge PCLK);
            k++;
        end
        if (k >= 2000) chk("rise_timeout", 0, 1);
    endtask

    // One frame of txv[0..n-1], checked against mode-0 rules.
    task automatic run_frame(input int n, input int div, input int mode, input int gap);
        int         b_rx;
        int         b_rise;
        int         b_done;
        int         k;
        logic [7:0] w;
        logic [7:0] exp;
        clk_div   = 8'(div);
        miso_mode = mode;
        for (int i = 0; i < 4; i++) slv[i] = 8'($urandom);
        b_rx   = rxq.size();
        b_rise = rise_t.size();
        b_done = done_cnt;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                k = 0;
                while (bus.tx_ready !== 1'b1 && k < 2000) begin
                    @(negedge PCLK);
                    k++;
                end
                repeat (gap) @(negedge PCLK);
                if (gap > 0) begin
                    chk("gap_nss", 32'(NSS), 0);
                    chk("gap_sck", 32'(SCK), 0);
                    chk("gap_busy", 32'(bus.busy), 1);
                end
            end
            send(txv[i], i == n - 1);
        end
        wait_done(b_done, 40 * n * (div + 1) + 100);
        chk("rx_count", 32'(rxq.size() - b_rx), 32'(n));
        chk("sck_rises", 32'(rise_t.size() - b_rise), 32'(8 * n));
        for (int i = 0; i < n; i++) begin
            exp = (mode == 0) ? txv[i] : (mode == 1) ? 8'hFF : slv[i];
            chk("rx_data", 32'(rxq[b_rx + i]), 32'(exp));
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[6:0], mbit[b_rise + 8 * i + j]};
            chk("mosi_word", 32'(w), 32'(txv[i]));
        end
        chk("sck_period", 32'(rise_t[b_rise + 1] - rise_t[b_rise]), 32'(20 * (div + 1)));
        if (n == 1) chk("frame_latency", 32'(done_t - acc_t), 32'(180 * (div + 1)));
        chk("done_count", 32'(done_cnt - b_done), 1);
        chk("end_nss", 32'(NSS), 1);
        chk("end_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        int b_rx;
        int b_rise;
        int b_done;
        bus.tx_valid = 1'b0;
        bus.tx_last  = 1'b0;
        bus.tx_data  = 8'h00;

        // Reset release
        #1 PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("rst_nss", 32'(NSS), 1);
        chk("rst_sck", 32'(SCK), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.tx_ready), 0);
        chk("rst_mosi", 32'(MOSI), 0);
        chk("rst_rxdata", 32'(bus.rx_data), 0);
        PRESET = 1'b0;
        #1 chk("ready_pre_clk", 32'(bus.tx_ready), 0);
        @(negedge PCLK);
        chk("ready_post_clk", 32'(bus.tx_ready), 1);

        // Single byte at PCLK/2
        txv[0] = 8'hA5;
        run_frame(1, 0, 0, 0);

        // Three-byte frame with producer gap
        txv[0] = 8'h01;
        txv[1] = 8'h80;
        txv[2] = 8'hFF;
        run_frame(3, 3, 0, 20);

        // MISO tied high, zero data out
        txv[0] = 8'h00;
        run_frame(1, 1, 1, 0);

        // Reset in the middle of a word
        clk_div   = 8'd1;
        miso_mode = 0;
        b_rx   = rxq.size();
        b_done = done_cnt;
        b_rise = rise_t.size();
        send(8'h3C, 1'b1);
        wait_rises(b_rise + 4);
        #2 PRESET = 1'b1;
        #1;
        chk("abort_nss", 32'(NSS), 1);
        chk("abort_sck", 32'(SCK), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("abort_no_rx", 32'(rxq.size() - b_rx), 0);
        chk("abort_no_done", 32'(done_cnt - b_done), 0);
        chk("abort_ready", 32'(bus.tx_ready), 1);
        txv[0] = 8'h3C;
        run_frame(1, 1, 0, 0);

        // clk_div change while shifting is ignored until the next frame
        clk_div   = 8'd1;
        miso_mode = 0;
        b_rise = rise_t.size();
        b_done = done_cnt;
        send(8'h5A, 1'b0);
        wait_rises(b_rise + 2);
        clk_div = 8'd7;
        send(8'hC3, 1'b1);
        wait_done(b_done, 2000);
        chk("div_hold_w0", 32'(rise_t[b_rise + 1] - rise_t[b_rise]), 40);
        chk("div_hold_w1", 32'(rise_t[b_rise + 9] - rise_t[b_rise + 8]), 40);
        txv[0] = 8'($urandom);
        run_frame(1, 7, 0, 0);

        // Random frames
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 4; i++) txv[i] = 8'($urandom);
            run_frame($urandom_range(1, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), $urandom_range(0, 5));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
